// File: rtl/knap_search.sv
// knap_search: exhaustive subset search over an item table, emitting every subset that meets
// the value/weight/volume thresholds. Define KNAP_SEARCH_BEST_TRACK_EN to enable best tracking.
`timescale 1ns/1ps
module knap_search #(
    parameter int unsigned N_ITEMS = 9,
    parameter int unsigned W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_idx,
    input  logic [W-1:0]       cfg_value,
    input  logic [W-1:0]       cfg_weight,
    input  logic [W-1:0]       cfg_volume,
    input  logic [W-1:0]       min_value,
    input  logic [W-1:0]       max_weight,
    input  logic [W-1:0]       max_volume,
    output logic               sol_valid,
    input  logic               sol_ready,
    output logic [N_ITEMS-1:0] sol_mask,
    output logic [W-1:0]       sol_value,
    output logic [N_ITEMS:0]   sol_count,
    output logic [N_ITEMS-1:0] best_mask,
    output logic [W-1:0]       best_value
);
    localparam int unsigned   KW     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_ITEMS - 1);

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_CHECK, S_EMIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [N_ITEMS-1:0] mask_q, mask_d;
    logic [KW-1:0]      k_q, k_d;
    logic [W-1:0]       vsum_q, vsum_d, wsum_q, wsum_d, osum_q, osum_d;
    logic [W-1:0]       minv_q, minv_d, maxw_q, maxw_d, maxo_q, maxo_d;
    logic [N_ITEMS:0]   cnt_q, cnt_d;
    logic               cand_ok, last_mask, advance;

    logic [W-1:0] item_val_q [N_ITEMS];
    logic [W-1:0] item_wt_q  [N_ITEMS];
    logic [W-1:0] item_vol_q [N_ITEMS];

    assign cand_ok   = (vsum_q >= minv_q) && (wsum_q <= maxw_q) && (osum_q <= maxo_q);
    assign last_mask = &mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_ITEMS; i++) begin
                item_val_q[i] <= '0;
                item_wt_q[i]  <= '0;
                item_vol_q[i] <= '0;
            end
        end else if (cfg_we && state_q == S_IDLE && 32'(cfg_idx) < N_ITEMS) begin
            item_val_q[cfg_idx] <= cfg_value;
            item_wt_q[cfg_idx]  <= cfg_weight;
            item_vol_q[cfg_idx] <= cfg_volume;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        k_d     = k_q;
        vsum_d  = vsum_q;
        wsum_d  = wsum_q;
        osum_d  = osum_q;
        minv_d  = minv_q;
        maxw_d  = maxw_q;
        maxo_d  = maxo_q;
        cnt_d   = cnt_q;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    mask_d  = '0;
                    k_d     = '0;
                    vsum_d  = '0;
                    wsum_d  = '0;
                    osum_d  = '0;
                    cnt_d   = '0;
                    minv_d  = min_value;
                    maxw_d  = max_weight;
                    maxo_d  = max_volume;
                end
            end
            S_ACCUM: begin
                if (mask_q[k_q]) begin
                    vsum_d = vsum_q + item_val_q[k_q];
                    wsum_d = wsum_q + item_wt_q[k_q];
                    osum_d = osum_q + item_vol_q[k_q];
                end
                if (k_q == K_LAST) state_d = S_CHECK;
                else               k_d     = k_q + 1'b1;
            end
            S_CHECK: begin
                if (cand_ok) state_d = S_EMIT;
                else         advance = 1'b1;
            end
            S_EMIT: begin
                if (sol_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    advance = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Shared exit from CHECK (rejected) and EMIT (accepted): next mask or finish.
        if (advance) begin
            if (last_mask) begin
                state_d = S_DONE;
            end else begin
                state_d = S_ACCUM;
                mask_d  = mask_q + 1'b1;
                k_d     = '0;
                vsum_d  = '0;
                wsum_d  = '0;
                osum_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            k_q     <= '0;
            vsum_q  <= '0;
            wsum_q  <= '0;
            osum_q  <= '0;
            minv_q  <= '0;
            maxw_q  <= '0;
            maxo_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            k_q     <= k_d;
            vsum_q  <= vsum_d;
            wsum_q  <= wsum_d;
            osum_q  <= osum_d;
            minv_q  <= minv_d;
            maxw_q  <= maxw_d;
            maxo_q  <= maxo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign sol_valid = (state_q == S_EMIT);
    assign sol_mask  = mask_q;
    assign sol_value = vsum_q;
    assign sol_count = cnt_q;

`ifdef KNAP_SEARCH_BEST_TRACK_EN
    logic [N_ITEMS-1:0] best_mask_q, best_mask_d;
    logic [W-1:0]       best_val_q, best_val_d;
    logic               best_seen_q, best_seen_d;

    // Strict '>' keeps the earlier (lower) mask on ties.
    always_comb begin
        best_mask_d = best_mask_q;
        best_val_d  = best_val_q;
        best_seen_d = best_seen_q;
        if (state_q == S_IDLE && start) begin
            best_mask_d = '0;
            best_val_d  = '0;
            best_seen_d = 1'b0;
        end else if (state_q == S_CHECK && cand_ok && (!best_seen_q || vsum_q > best_val_q)) begin
            best_mask_d = mask_q;
            best_val_d  = vsum_q;
            best_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_mask_q <= '0;
            best_val_q  <= '0;
            best_seen_q <= 1'b0;
        end else begin
            best_mask_q <= best_mask_d;
            best_val_q  <= best_val_d;
            best_seen_q <= best_seen_d;
        end
    end

    assign best_mask  = best_mask_q;
    assign best_value = best_val_q;
`else
    assign best_mask  = '0;
    assign best_value = '0;
`endif

endmodule

// File: tb/tb_knap_search.sv
// Self-checking bench for knap_search: every search is compared against an enumerate-all-subsets model.
`timescale 1ns/1ps
module tb_knap_search;
    localparam int N = 9;
    localparam int W = 8;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic         busy, done, sol_valid;
    logic         cfg_we = 1'b0, sol_ready = 1'b0;
    logic [3:0]   cfg_idx = '0;
    logic [W-1:0] cfg_value = '0, cfg_weight = '0, cfg_volume = '0;
    logic [W-1:0] min_value = '0, max_weight = '0, max_volume = '0;
    logic [N-1:0] sol_mask, best_mask;
    logic [W-1:0] sol_value, best_value;
    logic [N:0]   sol_count;

    always #5 clk = ~clk;

    knap_search #(.N_ITEMS(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value), .cfg_weight(cfg_weight),
        .cfg_volume(cfg_volume), .min_value(min_value), .max_weight(max_weight),
        .max_volume(max_volume), .sol_valid(sol_valid), .sol_ready(sol_ready),
        .sol_mask(sol_mask), .sol_value(sol_value), .sol_count(sol_count),
        .best_mask(best_mask), .best_value(best_value)
    );

    int n_chk = 0, n_fail = 0;
    int tv[N], tw[N], to[N];
    int exp_mask[$], exp_val[$];
    int n_inv, best_m, best_v;
    bit best_found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: enumerate all subsets in ascending order with plain modular arithmetic.
    function automatic void model(input int mn, input int mw, input int mv);
        exp_mask.delete();
        exp_val.delete();
        n_inv = 0; best_m = 0; best_v = 0; best_found = 0;
        for (int m = 0; m < (1 << N); m++) begin
            int sv = 0, sw = 0, so = 0;
            for (int i = 0; i < N; i++)
                if (((m >> i) & 1) == 1) begin sv += tv[i]; sw += tw[i]; so += to[i]; end
            sv = sv % 256; sw = sw % 256; so = so % 256;
            if (sv >= mn && sw <= mw && so <= mv) begin
                exp_mask.push_back(m);
                exp_val.push_back(sv);
                if (!best_found || sv > best_v) begin best_m = m; best_v = sv; best_found = 1; end
            end else begin
                n_inv++;
            end
        end
    endfunction

    task automatic load_table();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_idx = 4'(i);
            if (i < N) begin
                cfg_value = 8'(tv[i]); cfg_weight = 8'(tw[i]); cfg_volume = 8'(to[i]);
            end else begin
                cfg_value = 8'($urandom); cfg_weight = 8'($urandom); cfg_volume = 8'($urandom);
            end
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic set_table(input int v, input int w, input int o);
        for (int i = 0; i < N; i++) begin tv[i] = v; tw[i] = w; to[i] = o; end
    endtask

    task automatic run_search(input string nm, input int mn, input int mw, input int mv,
                              input int rdy_pct, input int hold_first, input int exp_cnt);
        int got = 0, cyc = 0, held = 0;
        bit r;
        model(mn, mw, mv);
        @(negedge clk);
        start = 1'b1; min_value = 8'(mn); max_weight = 8'(mw); max_volume = 8'(mv);
        @(negedge clk);
        start = 1'b0;
        chk({nm, "/busy_after_start"}, busy, 1);
        cyc = 1;
        while (!done && cyc < 20000) begin
            if (sol_valid) begin
                if (got < exp_mask.size()) begin
                    chk({nm, "/sol_mask"}, sol_mask, exp_mask[got]);
                    chk({nm, "/sol_value"}, sol_value, exp_val[got]);
                end else begin
                    chk({nm, "/extra_solution"}, sol_valid, 0);
                end
                if (held < hold_first) begin r = 1'b0; held++; end
                else r = ($urandom_range(0, 99) < rdy_pct);
                sol_ready = r;
                if (r) got++;
            end else begin
                sol_ready = 1'($urandom_range(0, 1));
            end
            // Traffic that a busy search must ignore.
            start      = ($urandom_range(0, 7) == 0);
            min_value  = 8'($urandom); max_weight = 8'($urandom); max_volume = 8'($urandom);
            cfg_we     = 1'($urandom_range(0, 1)); cfg_idx = 4'($urandom);
            cfg_value  = 8'($urandom); cfg_weight = 8'($urandom); cfg_volume = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; cfg_we = 1'b0; sol_ready = 1'b0;
        chk({nm, "/done_seen"}, done, 1);
        chk({nm, "/busy_in_done"}, busy, 1);
        chk({nm, "/accepted"}, got, exp_mask.size());
        chk({nm, "/sol_count"}, sol_count, exp_mask.size());
        if (exp_cnt >= 0) chk({nm, "/sol_count_const"}, sol_count, exp_cnt);
        if (rdy_pct == 100 && hold_first == 0)
            chk({nm, "/cycles"}, cyc, n_inv * (N + 1) + exp_mask.size() * (N + 2) + 1);
`ifdef KNAP_SEARCH_BEST_TRACK_EN
        chk({nm, "/best_mask"}, best_mask, best_m);
        chk({nm, "/best_value"}, best_value, best_v);
`else
        chk({nm, "/best_mask_tied"}, best_mask, 0);
        chk({nm, "/best_value_tied"}, best_value, 0);
`endif
        @(negedge clk);
        chk({nm, "/done_pulse_end"}, done, 0);
        chk({nm, "/idle_busy"}, busy, 0);
        chk({nm, "/idle_sol_valid"}, sol_valid, 0);
        chk({nm, "/count_hold"}, sol_count, exp_mask.size());
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "/busy"}, busy, 0);
        chk({nm, "/done"}, done, 0);
        chk({nm, "/sol_valid"}, sol_valid, 0);
        chk({nm, "/sol_mask"}, sol_mask, 0);
        chk({nm, "/sol_value"}, sol_value, 0);
        chk({nm, "/sol_count"}, sol_count, 0);
        chk({nm, "/best_mask"}, best_mask, 0);
        chk({nm, "/best_value"}, best_value, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Table is cleared by reset: with min_value=1 nothing qualifies
        set_table(0, 0, 0);
        run_search("cleared_table", 1, 0, 0, 100, 0, 0);

        // Every item {1,1,0}: exactly the popcount-3 subsets
        set_table(1, 1, 0);
        load_table();
        run_search("pick3", 3, 3, 0, 100, 0, 84);

        // Unconstrained: all 512 masks in order, 11 cycles each
        run_search("all", 0, 255, 255, 100, 0, 512);

        // Backpressure on the first solution, then random ready
        run_search("backpressure", 0, 255, 255, 60, 10, 512);

        // Best tracking with a weight cap and no value floor
        run_search("best", 0, 3, 0, 100, 0, -1);

        // Modular value sum: 200+100 wraps to 44
        set_table(0, 0, 0);
        tv[0] = 200; tv[1] = 100;
        load_table();
        run_search("wrap", 150, 0, 0, 100, 0, 128);

        // Random tables and thresholds
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < N; i++) begin
                tv[i] = $urandom_range(0, 255); tw[i] = $urandom_range(0, 60); to[i] = $urandom_range(0, 60);
            end
            load_table();
            run_search("random", $urandom_range(0, 255), $urandom_range(60, 200),
                       $urandom_range(60, 200), 70, 0, -1);
        end

        // Reset during ACCUM of mask 37 (all valid, ready high: mask m spans cycles 11m+1..11m+11)
        set_table(1, 1, 0);
        load_table();
        @(negedge clk);
        start = 1'b1; min_value = '0; max_weight = '1; max_volume = '1; sol_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 410; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_reset/no_done", done, 0);
        end
        rst_n = 1'b1;
        sol_ready = 1'b0;
        load_table();
        run_search("restart", 0, 255, 255, 100, 0, 512);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
